// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request/response handshake, with RISC-V B/H/W load extension and store lane merge.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [31:0]             mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              lane;
  logic [31:0]             rd_word;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic                    f3_legal;
  logic                    misaligned;
  logic                    access_err;
  logic                    access_now;
  logic                    mem_we;
  logic [31:0]             load_data;
  logic [31:0]             store_word;
  logic                    unused_addr_bits;

  // High address bits only alias the RAM, so they are deliberately dropped.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign word_idx   = addr_q[ADDR_WIDTH+1:2];
  assign lane       = addr_q[1:0];
  assign rd_word    = mem_q[word_idx];
  assign byte_sel   = rd_word[{lane, 3'b000} +: 8];
  assign half_sel   = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign access_err = !f3_legal || misaligned;
  assign mem_we     = access_now && we_q && !access_err && !rst;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    unique case (funct3_q)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !we_q;
      default:                f3_legal = 1'b0;
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    unique case (funct3_q)
      3'b001, 3'b101: misaligned = addr_q[0];
      3'b010:         misaligned = |addr_q[1:0];
      default:        misaligned = 1'b0;
    endcase
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    load_data  = 32'h0;
    store_word = rd_word;
    unique case (funct3_q)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_data = {24'h0, byte_sel};
      3'b001: load_data = {{16{half_sel[15]}}, half_sel};
      3'b101: load_data = {16'h0, half_sel};
      3'b010: load_data = rd_word;
      default: load_data = 32'h0;
    endcase
    unique case (funct3_q)
      3'b000: store_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      3'b001: begin
        if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
        else           store_word[15:0]  = wdata_q[15:0];
      end
      3'b010: store_word = wdata_q;
      default: store_word = rd_word;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr[ADDR_WIDTH+1:0];
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          cnt_d    = WAIT_INIT;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_RESP;
          err_d   = access_err;
          rdata_d = (access_err || we_q) ? 32'h0 : load_data;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // RAM has no reset; a reset on the access edge suppresses the write through mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[word_idx] <= store_word;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 runs with WAIT_CYCLES=3, instance 1 with WAIT_CYCLES=2 for the aborted-store case.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  int tests    = 0;
  int failures = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_funct3(req_funct3[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_funct3(req_funct3[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response with rsp_ready held high; bounded wait for the response.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [2:0] f3,
                               output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata; req_funct3[d] = f3;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_arrives", {31'h0, rsp_valid[d]}, 32'h1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(posedge clk);
  endtask

  task automatic doAccess(input int d, input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] expRd, input logic expErr);
    logic [31:0] rd;
    logic        er;
    applyStimulus(d, we, addr, wdata, f3, rd, er);
    checkOutput({tag, "_rdata"}, rd, expRd);
    checkOutput({tag, "_err"}, {31'h0, er}, {31'h0, expErr});
  endtask

  initial begin
    int n;
    logic sawRsp;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_funct3[d] = 3'b010; rsp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    checkOutput("por_req_ready", {31'h0, req_ready[0]}, 32'h1);
    checkOutput("por_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    checkOutput("por_rsp_rdata", rsp_rdata[0], 32'h0);
    checkOutput("por_rsp_err",   {31'h0, rsp_err[0]}, 32'h0);

    // Sign/zero extension over one known word
    doAccess(0, "sw_init", 1'b1, 32'h20, 32'h80FF7F01, 3'b010, 32'h0, 1'b0);
    doAccess(0, "lb_21",  1'b0, 32'h21, 32'h0, 3'b000, 32'h0000007F, 1'b0);
    doAccess(0, "lb_23",  1'b0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    doAccess(0, "lbu_23", 1'b0, 32'h23, 32'h0, 3'b100, 32'h00000080, 1'b0);
    doAccess(0, "lh_22",  1'b0, 32'h22, 32'h0, 3'b001, 32'hFFFF80FF, 1'b0);
    doAccess(0, "lhu_20", 1'b0, 32'h20, 32'h0, 3'b101, 32'h00007F01, 1'b0);
    doAccess(0, "lw_20",  1'b0, 32'h20, 32'h0, 3'b010, 32'h80FF7F01, 1'b0);
    doAccess(0, "lw_wrap", 1'b0, 32'h1020, 32'h0, 3'b010, 32'h80FF7F01, 1'b0);

    // Byte-lane merge
    doAccess(0, "sb_21", 1'b1, 32'h21, 32'hFFFFFFAB, 3'b000, 32'h0, 1'b0);
    doAccess(0, "sh_22", 1'b1, 32'h22, 32'hABCD1234, 3'b001, 32'h0, 1'b0);
    doAccess(0, "lw_merge", 1'b0, 32'h20, 32'h0, 3'b010, 32'h1234AB01, 1'b0);

    // Latency with WAIT_CYCLES=3, then backpressure with an ignored store attempt
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[0] = 32'h20; req_funct3[0] = 3'b010;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("lat_valid_edge%0d", i), {31'h0, rsp_valid[0]}, (i == 4) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hDEADBEEF;
      req_funct3[0] = 3'b010; req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("bp_valid_%0d", i), {31'h0, rsp_valid[0]}, 32'h1);
      checkOutput($sformatf("bp_rdata_%0d", i), rsp_rdata[0], 32'h1234AB01);
      checkOutput($sformatf("bp_ready_%0d", i), {31'h0, req_ready[0]}, 32'h0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("hs_req_ready", {31'h0, req_ready[0]}, 32'h1);
    checkOutput("hs_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    doAccess(0, "lw_after_bp", 1'b0, 32'h20, 32'h0, 3'b010, 32'h1234AB01, 1'b0);

    // Error responses
`ifdef DMEM_ALIGN_CHECK_EN
    doAccess(0, "lw_mis", 1'b0, 32'h22, 32'h0, 3'b010, 32'h0, 1'b1);
    doAccess(0, "sw_mis", 1'b1, 32'h22, 32'hDEADBEEF, 3'b010, 32'h0, 1'b1);
    doAccess(0, "lw_after_mis", 1'b0, 32'h20, 32'h0, 3'b010, 32'h1234AB01, 1'b0);
    doAccess(0, "lh_mis", 1'b0, 32'h21, 32'h0, 3'b001, 32'h0, 1'b1);
`else
    doAccess(0, "lw_unal", 1'b0, 32'h22, 32'h0, 3'b010, 32'h1234AB01, 1'b0);
    doAccess(0, "lhu_unal", 1'b0, 32'h23, 32'h0, 3'b101, 32'h00001234, 1'b0);
`endif
    doAccess(0, "f3_011", 1'b0, 32'h20, 32'h0, 3'b011, 32'h0, 1'b1);
    doAccess(0, "st_f3_100", 1'b1, 32'h20, 32'hCAFEF00D, 3'b100, 32'h0, 1'b1);
    doAccess(0, "lw_after_err", 1'b0, 32'h20, 32'h0, 3'b010, 32'h1234AB01, 1'b0);

    // Reset while a response is pending drops it
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[0] = 32'h20; req_funct3[0] = 3'b010;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pend_rdata", rsp_rdata[0], 32'h1234AB01);
    rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    checkOutput("mid_req_ready", {31'h0, req_ready[0]}, 32'h1);
    checkOutput("mid_rsp_valid", {31'h0, rsp_valid[0]}, 32'h0);
    checkOutput("mid_rsp_rdata", rsp_rdata[0], 32'h0);
    checkOutput("mid_rsp_err",   {31'h0, rsp_err[0]}, 32'h0);

    // Reset on the access edge of a store (WAIT_CYCLES=2) abandons the write
    doAccess(1, "abort_pre_sw", 1'b1, 32'h20, 32'h11111111, 3'b010, 32'h0, 1'b0);
    @(negedge clk);
    req_we[1] = 1'b1; req_addr[1] = 32'h20; req_wdata[1] = 32'h22222222;
    req_funct3[1] = 3'b010; req_valid[1] = 1'b1; rsp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_rsp_valid", {31'h0, rsp_valid[1]}, 32'h0);
    checkOutput("abort_req_ready", {31'h0, req_ready[1]}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    sawRsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) sawRsp = 1'b1;
    end
    checkOutput("abort_no_rsp", {31'h0, sawRsp}, 32'h0);
    doAccess(1, "abort_lw", 1'b0, 32'h20, 32'h0, 3'b010, 32'h11111111, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: it serves load/store requests issued by the datapath's data-memory port (byte address, store data, access width) and returns read data through a valid/ready handshake. It is word-organised on-chip RAM with configurable wait states and RISC-V byte/half/word semantics: byte-lane merge on stores, sign/zero extension on loads. It sits between the core's memory-stage signals and RAM, and replaces the ideal zero-latency data memory for multi-cycle bring-up.

## Interface
- ADDR_WIDTH, 10: word-address bits; depth = 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1: extra access wait states, legal range 0..15.

- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (the byte or half is in the low bits).
- req_funct3  in  3  RISC-V width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  request rejected, no memory side effect.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE:** req_ready=1. If req_valid is high at an edge, latch we/addr/wdata/funct3, load wait counter with WAIT_CYCLES, and go to WAIT.
- **WAIT:**
  - At each edge with counter≠0, decrement.
  - At the edge with counter==0, perform the access, register rsp_rdata/rsp_err, and go to RESP.
- **RESP:** rsp_valid=1. At an edge with rsp_ready=1, go to IDLE. Outputs are held stable while rsp_ready=0.
- **Indexing:** word index = addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH bytes.
- **Loads:**
  - B/BU: select lane addr[1:0].
  - H/HU: select half addr[1].
  - W: full word.
  - B and H sign-extend; BU and HU zero-extend.
- **Stores:** read-modify-write of one word.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes half addr[1] with wdata[15:0].
  - SW writes all four lanes.
  - Other lanes are unchanged. Store response: rdata=0, err=0.
  - funct3 100/101 with we=1 is an error.
- **Illegal funct3** (011, 110, 111): err=1, rdata=0, no write.
- Request inputs are ignored outside IDLE.
- RAM contents are not reset; simulation initial content is don't-care.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- **Latency:** request accepted at edge E; memory access at edge E+1+WAIT_CYCLES; rsp_valid first high in the cycle after that edge.
- After a response handshake at edge F, req_ready is high from edge F onward. There is no same-cycle accept of the next request.
- **Minimum throughput:** one request per WAIT_CYCLES+3 cycles.
- **Reset priority:** rst high at any edge overrides all other activity. A pending store is abandoned unwritten, even if rst coincides with the access edge. A pending response is dropped.
- rsp_valid never depends combinationally on rsp_ready. req_ready is a decode of state only.

## Configuration
- Macro: DMEM_ALIGN_CHECK_EN.
- **Defined:**
  - Misaligned H/HU (addr[0]=1) or W (addr[1:0]≠00) gives err=1, rdata=0, no write.
  - Byte accesses are never misaligned.
- **Undefined:**
  - No alignment errors.
  - H/HU ignore addr[0]; W ignores addr[1:0]. The access proceeds on the aligned half or word.
  - Illegal-funct3 errors still apply.

## Test plan
- **Reset:** hold rst for 2 cycles mid-stream → rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 in the cycle after reset deassertion.
- **Extension:** SW 0x80FF7F01 to 0x20, then:
  - LB 0x21 → 0x0000007F
  - LB 0x23 → 0xFFFFFF80
  - LBU 0x23 → 0x00000080
  - LH 0x22 → 0xFFFF80FF
  - LHU 0x20 → 0x00007F01
  - LW 0x20 → 0x80FF7F01
- **Byte merge:** over the same word, SB 0x...AB to 0x21 and SH 0x...1234 to 0x22 → LW 0x20 returns 0x1234AB01.
- **Latency and backpressure:** WAIT_CYCLES=3, accept at edge 0 → rsp_valid first high after edge 4. With rsp_ready held 0 for 5 cycles, rsp_valid/rsp_rdata stay stable and req_ready=0. A new req_valid during this time is ignored.
- **Errors:**
  - With DMEM_ALIGN_CHECK_EN: LW 0x22 → err=1, rdata=0. SW 0xDEADBEEF to 0x22 does not write; verify with LW 0x20.
  - Without the macro: LW 0x22 returns the word at 0x20 with err=0.
  - Both builds: funct3=011 → err=1.
- **Reset mid-store:** with word 0x20=0x11111111, issue SW 0x22222222 to 0x20 with WAIT_CYCLES=2 and assert rst on the access edge → LW 0x20 returns 0x11111111, and no response is produced for the aborted store.
